pcdec8_timer: RTL and testbench

- Registered loadable down-counter/timer: the decrementing counterpart of the team's 8-bit loadable up-counter next-state logic.
- Same control set: synchronous clear, parallel load, count enable, cascade borrow-in, plus a borrow-out for chaining.
- Adds a reload register and a one-shot/auto-reload state machine, so it can serve as a programmable interval timer next to the up-counters.

---
 rtl/pcdec_pkg.sv | 26 ++
 rtl/pcdec8_timer.sv | 91 +++++++++
 tb/tb_pcdec8_timer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcdec_pkg.sv
// Shared definitions for the loadable counter family (state enum, width, expiry test).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pcdec_pkg;

    // Default counter width, shared with the up-counter family.
    localparam int PCDEC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // never loaded, or cleared since
        RUN  = 2'd1,   // counting allowed
        DONE = 2'd2    // one-shot expired, holding at zero
    } pcdec_state_t;

    // Expiry happens on a qualified decrement while the count already sits at zero.
    // The caller supplies the zero test so this stays independent of counter width.
    function automatic logic pcdec_expiry(
        input logic         cnt_zero,
        input pcdec_state_t state,
        input logic         en,
        input logic         bin
    );
        return en & bin & cnt_zero & (state == RUN);
    endfunction

endpackage

// File: rtl/pcdec8_timer.sv
// Loadable down-counter / interval timer with reload register and one-shot/auto-reload FSM.
// Latency: cnt, tc, running update one clock after the controlling input; bout is combinational.
// Backpressure: none; en & bin qualify each decrement, bout chains borrows to the next stage.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   clr             synchronous clear to IDLE (highest priority), reload register kept
//   ld, ld_val      synchronous load of count and reload register, enters RUN
//   en, bin         count enable and cascade borrow-in; both needed to decrement
//   cnt             registered count
//   bout            borrow-out: this stage expires on the coming edge
//   tc              registered one-cycle pulse after each expiry
//   running         high while in RUN
module pcdec8_timer
    import pcdec_pkg::*;
#(
    parameter int WIDTH       = PCDEC_WIDTH,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             bin,
    output logic [WIDTH-1:0] cnt,
    output logic             bout,
    output logic             tc,
    output logic             running
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    pcdec_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             dec;
    logic             expire;

    assign dec    = (state_q == RUN) & en & bin;
    assign expire = pcdec_expiry(cnt_q == '0, state_q, en, bin);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        tc_d     = 1'b0;       // tc is a pulse: drops unless this edge expires

        if (clr) begin
            cnt_d   = '0;
            state_d = IDLE;
        end else if (ld) begin
            // ld beats a simultaneous expiry, so no tc on that edge
            cnt_d    = ld_val;
            reload_d = ld_val;
            state_d  = RUN;
        end else if (dec) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end else if (AUTO_RELOAD) begin
                cnt_d = reload_q;
                tc_d  = 1'b1;
            end else begin
                tc_d    = 1'b1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_q;
    assign bout    = expire;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_pcdec8_timer.sv
// Directed self-checking bench for pcdec8_timer: auto-reload, one-shot, cascade,
// priority collisions, gating and asynchronous reset.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_pcdec8_timer;

    logic clk;
    logic rst_n;

    // auto-reload instance
    logic       clr_a, ld_a, en_a, bin_a;
    logic [7:0] ld_val_a;
    logic [7:0] cnt_a;
    logic       bout_a, tc_a, running_a;

    // one-shot instance
    logic       clr_o, ld_o, en_o, bin_o;
    logic [7:0] ld_val_o;
    logic [7:0] cnt_o;
    logic       bout_o, tc_o, running_o;

    // cascaded pair
    logic       c_clr, c_ld, c_en;
    logic [7:0] c_ld_val;
    logic [7:0] cnt_lo, cnt_hi;
    logic       bout_lo, bout_hi, tc_lo, tc_hi, running_lo, running_hi;
    logic       c_bin_lo;

    int checks;
    int errors;

    pcdec8_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .ld(ld_a), .ld_val(ld_val_a),
        .en(en_a), .bin(bin_a), .cnt(cnt_a), .bout(bout_a), .tc(tc_a), .running(running_a)
    );

    pcdec8_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut_o (
        .clk(clk), .rst_n(rst_n), .clr(clr_o), .ld(ld_o), .ld_val(ld_val_o),
        .en(en_o), .bin(bin_o), .cnt(cnt_o), .bout(bout_o), .tc(tc_o), .running(running_o)
    );

    pcdec8_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .ld(c_ld), .ld_val(c_ld_val),
        .en(c_en), .bin(c_bin_lo), .cnt(cnt_lo), .bout(bout_lo), .tc(tc_lo), .running(running_lo)
    );

    pcdec8_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .ld(c_ld), .ld_val(c_ld_val),
        .en(c_en), .bin(bout_lo), .cnt(cnt_hi), .bout(bout_hi), .tc(tc_hi), .running(running_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // auto-reload sequence starting from cnt = 3 under continuous enable
    logic [7:0] auto_cnt_exp [8] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    logic       auto_tc_exp  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    // bout before each edge: high exactly when cnt was 0 going in
    logic       auto_bo_exp  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    // cascade {hi,lo} after each edge starting from 0x0101
    logic [15:0] casc_exp    [4] = '{16'h0100, 16'h0001, 16'h0000, 16'h0101};
    logic        casc_tc_lo  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        casc_tc_hi  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clr_a = 0; ld_a = 0; en_a = 0; bin_a = 0; ld_val_a = 8'h00;
        clr_o = 0; ld_o = 0; en_o = 0; bin_o = 0; ld_val_o = 8'h00;
        c_clr = 0; c_ld = 0; c_en = 0; c_ld_val = 8'h00; c_bin_lo = 1'b1;

        tick();
        tick();
        chk("reset_cnt",     32'(cnt_a),     32'h0);
        chk("reset_tc",      32'(tc_a),      32'h0);
        chk("reset_running", 32'(running_a), 32'h0);
        chk("reset_reload",  32'(dut_a.reload_q), 32'h0);
        rst_n = 1'b1;

        // IDLE ignores en/bin
        en_a = 1; bin_a = 1;
        #1;
        chk("idle_bout", 32'(bout_a), 32'h0);
        tick();
        tick();
        chk("idle_cnt",     32'(cnt_a),     32'h0);
        chk("idle_running", 32'(running_a), 32'h0);
        chk("idle_tc",      32'(tc_a),      32'h0);

        // auto-reload, period 4
        ld_val_a = 8'd3; ld_a = 1;
        tick();
        ld_a = 0;
        chk("ld3_cnt",     32'(cnt_a),     32'h3);
        chk("ld3_running", 32'(running_a), 32'h1);
        chk("ld3_tc",      32'(tc_a),      32'h0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("auto_bout[%0d]", i), 32'(bout_a), 32'(auto_bo_exp[i]));
            tick();
            chk($sformatf("auto_cnt[%0d]", i), 32'(cnt_a), 32'(auto_cnt_exp[i]));
            chk($sformatf("auto_tc[%0d]", i),  32'(tc_a),  32'(auto_tc_exp[i]));
        end

        // bin low gates the decrement
        bin_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("gate_cnt[%0d]", i),  32'(cnt_a),  32'h3);
            chk($sformatf("gate_bout[%0d]", i), 32'(bout_a), 32'h0);
        end
        chk("gate_tc", 32'(tc_a), 32'h0);

        // bring count to 0, then collide ld with expiry
        bin_a = 1;
        tick(); tick(); tick();
        chk("to_zero_cnt", 32'(cnt_a), 32'h0);
        ld_a = 1; ld_val_a = 8'hA5;
        #1;
        chk("collide_bout", 32'(bout_a), 32'h1);
        tick();
        chk("ld_wins_cnt", 32'(cnt_a), 32'hA5);
        chk("ld_wins_tc",  32'(tc_a),  32'h0);

        // clr beats ld; reload register keeps the previous load
        clr_a = 1; ld_a = 1; ld_val_a = 8'h11;
        tick();
        clr_a = 0; ld_a = 0;
        chk("clr_wins_cnt",     32'(cnt_a),     32'h0);
        chk("clr_wins_running", 32'(running_a), 32'h0);
        chk("clr_wins_tc",      32'(tc_a),      32'h0);
        chk("clr_keeps_reload", 32'(dut_a.reload_q), 32'hA5);

        // load 0 with auto-reload: expires every cycle, tc held high
        ld_a = 1; ld_val_a = 8'h00;
        tick();
        ld_a = 0;
        chk("ld0_cnt", 32'(cnt_a), 32'h0);
        chk("ld0_tc",  32'(tc_a),  32'h0);
        tick();
        chk("ld0_tc1", 32'(tc_a),  32'h1);
        chk("ld0_cnt1", 32'(cnt_a), 32'h0);
        tick();
        chk("ld0_tc2", 32'(tc_a),  32'h1);

        // one-shot: 2,1,0 then DONE
        ld_val_o = 8'd2; ld_o = 1;
        tick();
        ld_o = 0; en_o = 1; bin_o = 1;
        chk("os_ld_cnt", 32'(cnt_o), 32'h2);
        tick();
        chk("os_cnt1", 32'(cnt_o), 32'h1);
        tick();
        chk("os_cnt0", 32'(cnt_o), 32'h0);
        chk("os_tc0",  32'(tc_o),  32'h0);
        chk("os_run0", 32'(running_o), 32'h1);
        tick();
        chk("os_exp_cnt", 32'(cnt_o),     32'h0);
        chk("os_exp_tc",  32'(tc_o),      32'h1);
        chk("os_exp_run", 32'(running_o), 32'h0);
        tick();
        chk("os_done_tc",   32'(tc_o),   32'h0);
        chk("os_done_cnt",  32'(cnt_o),  32'h0);
        chk("os_done_bout", 32'(bout_o), 32'h0);
        ld_val_o = 8'd5; ld_o = 1;
        tick();
        ld_o = 0;
        chk("os_reld_cnt", 32'(cnt_o),     32'h5);
        chk("os_reld_run", 32'(running_o), 32'h1);
        tick();
        chk("os_reld_dec", 32'(cnt_o), 32'h4);

        // cascade: 0x0101 counts down to 0x0000 then reloads
        c_ld_val = 8'h01; c_ld = 1;
        tick();
        c_ld = 0; c_en = 1;
        chk("casc_ld", 32'({cnt_hi, cnt_lo}), 32'h0101);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("casc_val[%0d]", i),   32'({cnt_hi, cnt_lo}), 32'(casc_exp[i]));
            chk($sformatf("casc_tc_lo[%0d]", i), 32'(tc_lo), 32'(casc_tc_lo[i]));
            chk($sformatf("casc_tc_hi[%0d]", i), 32'(tc_hi), 32'(casc_tc_hi[i]));
        end
        c_en = 0;

        // asynchronous reset mid-count at 0x37
        ld_val_a = 8'h38; ld_a = 1; en_a = 1; bin_a = 1;
        tick();
        ld_a = 0;
        chk("pre_rst_ld", 32'(cnt_a), 32'h38);
        tick();
        chk("pre_rst_cnt", 32'(cnt_a), 32'h37);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",     32'(cnt_a),     32'h0);
        chk("arst_tc",      32'(tc_a),      32'h0);
        chk("arst_running", 32'(running_a), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_cnt",     32'(cnt_a),     32'h0);
        chk("post_rst_running", 32'(running_a), 32'h0);
        chk("post_rst_bout",    32'(bout_a),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
